// File: rtl/ebus_xfer_if.sv
// ebus_xfer_if: request, EBUS handshake and EDP data signals of the EBUS transfer sequencer.
interface ebus_xfer_if;
  logic        start;
  logic        isWrite;
  logic [0:6]  csIn;
  logic [0:2]  funcIn;
  logic [0:35] AD;
  logic [0:35] ebusDataIn;
  logic        xfer;
  logic [0:6]  cs;
  logic [0:2]  func;
  logic        demand;
  logic [0:35] ebusDataOut;
  logic        AD_TO_EBUS_L;
  logic        AD_TO_EBUS_R;
  logic [0:35] rdData;
  logic        rdLoad;
  logic        busy;
  logic        done;
  logic        timeout;
  modport master (
    input  start, isWrite, csIn, funcIn, AD, ebusDataIn, xfer,
    output cs, func, demand, ebusDataOut, AD_TO_EBUS_L, AD_TO_EBUS_R,
           rdData, rdLoad, busy, done, timeout
  );
  modport slave (
    output start, isWrite, csIn, funcIn, AD, ebusDataIn, xfer,
    input  cs, func, demand, ebusDataOut, AD_TO_EBUS_L, AD_TO_EBUS_R,
           rdData, rdLoad, busy, done, timeout
  );
endinterface

// File: rtl/ebus_xfer.sv
// ebus_xfer: EBOX-side EBUS transfer sequencer (CS/FUNC setup, DEMAND/XFER handshake, timeout).
module ebus_xfer #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input logic         clk,
  input logic         CROBAR,
  ebus_xfer_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, DEMAND, HOLD, DONE} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_write;
  logic             r_seen;
  logic             w_cnt_last;
  logic             w_abort;
  logic             w_fin;
  assign w_cnt_last = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign w_abort    = w_cnt_last && ((r_state == DEMAND && !bus.xfer) || (r_state == HOLD && bus.xfer));
  assign w_fin      = w_abort || (r_state == HOLD && !bus.xfer);
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_write          <= 1'b0;
      r_seen           <= 1'b0;
      bus.cs           <= '0;
      bus.func         <= '0;
      bus.demand       <= 1'b0;
      bus.ebusDataOut  <= '0;
      bus.AD_TO_EBUS_L <= 1'b0;
      bus.AD_TO_EBUS_R <= 1'b0;
      bus.rdData       <= '0;
      bus.rdLoad       <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.timeout      <= 1'b0;
    end else begin
      bus.done   <= 1'b0;
      bus.rdLoad <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state          <= SETUP;
          r_cnt            <= '0;
          r_write          <= bus.isWrite;
          r_seen           <= 1'b0;
          bus.cs           <= bus.csIn;
          bus.func         <= bus.funcIn;
          bus.AD_TO_EBUS_L <= bus.isWrite;
          bus.AD_TO_EBUS_R <= bus.isWrite;
          bus.busy         <= 1'b1;
          bus.timeout      <= 1'b0;
          if (bus.isWrite) bus.ebusDataOut <= bus.AD;
        end
        SETUP: if (r_cnt == CNT_W'(SETUP_CYCLES - 1)) begin
          r_cnt      <= '0;
          r_state    <= DEMAND;
          bus.demand <= 1'b1;
        end else r_cnt <= r_cnt + 1'b1;
        DEMAND: if (bus.xfer) begin
          r_state    <= HOLD;
          r_cnt      <= '0;
          r_seen     <= 1'b1;
          bus.demand <= 1'b0;
          if (!r_write) bus.rdData <= bus.ebusDataIn;
        end else if (!w_fin) r_cnt <= r_cnt + 1'b1;
        HOLD: if (!w_fin) r_cnt <= r_cnt + 1'b1;
        DONE: begin
          r_state  <= IDLE;
          bus.busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
      // Normal release and both abort paths converge here; timeout was cleared at start.
      if (w_fin) begin
        r_state          <= DONE;
        r_cnt            <= '0;
        bus.done         <= 1'b1;
        bus.rdLoad       <= !r_write && r_seen;
        bus.timeout      <= w_abort;
        bus.cs           <= '0;
        bus.func         <= '0;
        bus.demand       <= 1'b0;
        bus.AD_TO_EBUS_L <= 1'b0;
        bus.AD_TO_EBUS_R <= 1'b0;
      end
    end
  end
endmodule

// File: doc/ebus_xfer.md
Name: ebus_xfer

Overview:
- EBOX-side EBUS transfer sequencer, directly downstream of the EDP.
- For writes (CONO/DATAO), it gates EDP AD onto the EBUS.
- For reads (CONI/DATAI), it captures EBUS data for the EDP to load into AR.
- It owns the CS/FUNC/DEMAND/XFER handshake with EBUS devices, including setup delay and a no-response timeout.

Parameters:
SETUP_CYCLES, 2, cycles CS/FUNC/data are held stable before DEMAND asserts (minimum 1)
TIMEOUT_CYCLES, 64, maximum cycles to wait for each XFER edge before aborting (minimum 2)
CNT_W, 8, width of the shared setup/timeout counter; must hold max(SETUP_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  in  1  EBOX clock
CROBAR  in  1  reset; synchronous, active-high
start  in  1  one-cycle request from CON; sampled only in IDLE
isWrite  in  1  1 = EBOX drives data (CONO/DATAO), 0 = device drives (CONI/DATAI); sampled with start
csIn  in  7 [0:6]  device controller select, sampled with start
funcIn  in  3 [0:2]  EBUS function code, sampled with start
AD  in  36 [0:35]  EDP adder output, sampled with start for writes
ebusDataIn  in  36 [0:35]  EBUS data lines as driven by a device
xfer  in  1  device transfer acknowledge
cs  out  7 [0:6]  EBUS CS, registered
func  out  3 [0:2]  EBUS FUNC, registered
demand  out  1  EBUS DEMAND, registered
ebusDataOut  out  36 [0:35]  write data latched from AD
AD_TO_EBUS_L  out  1  enable left-half drive of ebusDataOut
AD_TO_EBUS_R  out  1  enable right-half drive of ebusDataOut
rdData  out  36 [0:35]  captured read data, presented to the EDP as the EBUS source
rdLoad  out  1  one-cycle strobe: rdData valid, load AR
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
timeout  out  1  sticky; set on abort, cleared by the next accepted start

Behaviour:
- Reset values: all outputs 0; state = IDLE; counter = 0. Reset in any state forces this on the next edge, including mid-handshake. DEMAND drops immediately and no done pulse is produced.
- IDLE:
  - start=1 latches isWrite, csIn, funcIn and (writes only) AD into ebusDataOut.
  - Clears timeout; counter = 0; go to SETUP.
  - start while not IDLE is ignored; no queuing.
- SETUP:
  - cs and func are driven.
  - For writes, AD_TO_EBUS_L and AD_TO_EBUS_R are both 1 from SETUP through HOLD.
  - Counter increments; at counter == SETUP_CYCLES-1, counter = 0 and go to DEMAND.
- DEMAND:
  - demand = 1.
  - xfer=1 → go to HOLD. For reads, rdData <= ebusDataIn on that same edge.
  - Otherwise the counter increments. At counter == TIMEOUT_CYCLES-1 → timeout <= 1 and go to DONE. rdData is unchanged and rdLoad is not pulsed.
- HOLD:
  - demand = 0; cs, func and write drive are held.
  - Counter restarts at 0.
  - xfer=0 → DONE. If xfer stays high TIMEOUT_CYCLES cycles → timeout <= 1 and go to DONE. Data already captured remains valid.
- DONE (1 cycle):
  - done = 1.
  - rdLoad = 1 only if the transfer was a read and xfer was seen in DEMAND.
  - cs, func, AD_TO_EBUS_L/R and demand = 0. Return to IDLE.
- Latency: a successful transfer with device acknowledge delay d and release delay r spans SETUP_CYCLES + (d+1) + (r+1) + 1 cycles from the start edge.
- xfer=1 already present on entry to DEMAND completes in one cycle. xfer outside DEMAND/HOLD is ignored.
- AD_TO_EBUS_L/R are never 1 for reads. demand and AD_TO_EBUS_* are never 1 in IDLE or DONE.

Test Plan:
- Write: start, isWrite=1, cs=7'o14, func=3'b001, AD=36'h555555555; device raises xfer 3 cycles after demand and drops it 2 cycles later. Required: cs/func valid 2 cycles before demand; ebusDataOut=h555555555 with L/R enables high; done after 2+4+3+1 cycles; rdLoad=0, timeout=0.
- Read: start, isWrite=0, ebusDataIn=36'h987654321 at the xfer edge, then changed to 0. Required: rdData=h987654321, a single rdLoad pulse coincident with done, AD_TO_EBUS_* never asserted.
- No response: xfer held 0. Required: demand high exactly 64 cycles, then done with timeout=1, rdLoad=0; a following start clears timeout.
- Stuck xfer: xfer stays 1 after acknowledge. Required: HOLD aborts after 64 cycles, timeout=1, and for a read rdLoad=1 with the captured data.
- Busy/reset: start pulsed during DEMAND is ignored (cs unchanged). CROBAR asserted in HOLD gives all outputs 0 next cycle with no done pulse; start one cycle later is accepted normally.
